// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: raster position, sync and blanking flags, and pixel colour.
// The generator drives it through the out modport, and downstream stages read it through in.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator. Counts, flags, frame pulse and frame counter are all registered.
// Flags come from the next-count values, so each flag lines up with the count shown in the same cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE     = 800,
    parameter int H_SYNC_START = 840,
    parameter int H_SYNC_END   = 968,
    parameter int H_TOTAL      = 1056,
    parameter int V_ACTIVE     = 600,
    parameter int V_SYNC_START = 601,
    parameter int V_SYNC_END   = 605,
    parameter int V_TOTAL      = 628
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if.out          vga_out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= 2048)) begin : g_bad_h_timing
        $error("vga_timing_gen: horizontal timing parameters out of order");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
          V_SYNC_END <= V_TOTAL && V_TOTAL <= 2048)) begin : g_bad_v_timing
        $error("vga_timing_gen: vertical timing parameters out of order");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
    localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
    // A sync end may sit at 2048, one past the 11-bit range, so it gets a spare bit.
    localparam logic [11:0] H_SE   = 12'(H_SYNC_END);
    localparam logic [11:0] V_SE   = 12'(V_SYNC_END);

    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic        frame_start_q;
    logic [15:0] frame_cnt_q;

    logic [10:0] h_next, v_next;
    logic        frame_wrap;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        h_next     = hcount_q;
        v_next     = vcount_q;
        frame_wrap = 1'b0;
        if (en) begin
            if (hcount_q == H_LAST) begin
                h_next = 11'd0;
                if (vcount_q == V_LAST) begin
                    v_next     = 11'd0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = vcount_q + 11'd1;
                end
            end else begin
                h_next = hcount_q + 11'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            hcount_q      <= h_next;
            vcount_q      <= v_next;
            hsync_q       <= (h_next >= H_SS) && ({1'b0, h_next} < H_SE);
            vsync_q       <= (v_next >= V_SS) && ({1'b0, v_next} < V_SE);
            hblnk_q       <= (h_next >= H_ACT);
            vblnk_q       <= (v_next >= V_ACT);
            frame_start_q <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = 12'h000;
    assign frame_start    = frame_start_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small-parameter instance.
// Both are checked against a model that derives the raster position from the count of enabled cycles.
module tb_vga_timing_gen;

    localparam longint D_HA = 800, D_HSS = 840, D_HSE = 968, D_HT = 1056;
    localparam longint D_VA = 600, D_VSS = 601, D_VSE = 605, D_VT = 628;
    localparam longint D_F  = D_HT * D_VT;
    localparam longint S_HA = 4, S_HSS = 5, S_HSE = 6, S_HT = 8;
    localparam longint S_VA = 2, S_VSS = 3, S_VSE = 4, S_VT = 5;
    localparam longint S_F  = S_HT * S_VT;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb, fs;
        logic [15:0] fc;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        bit   rst;
        bit   en;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d = 1'b1, en_d = 1'b0, rst_s = 1'b1, en_s = 1'b0;
    logic        fs_d, fs_s;
    logic [15:0] fc_d, fc_s;
    vga_if vif_d ();
    vga_if vif_s ();

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst_d), .en(en_d), .vga_out(vif_d),
        .frame_start(fs_d), .frame_cnt(fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_SYNC_START(5), .H_SYNC_END(6), .H_TOTAL(8),
        .V_ACTIVE(2), .V_SYNC_START(3), .V_SYNC_END(4), .V_TOTAL(5)
    ) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .vga_out(vif_s),
        .frame_start(fs_s), .frame_cnt(fc_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: enabled cycles since reset, frame-count base, and last-cycle frame pulse.
    longint n_dm = 0, fcb_dm = 0, n_sm = 0, fcb_sm = 0;
    bit     fs_dm = 1'b0, fs_sm = 1'b0;

    logic [10:0] frc_h, frc_v;
    logic [15:0] frc_fc;

    function automatic obs_t model(input longint n, input longint fcb, input bit fs,
                                   input longint ha, input longint hss, input longint hse,
                                   input longint ht, input longint va, input longint vss,
                                   input longint vse, input longint vt);
        obs_t   o;
        longint p, h, v;
        p     = n % (ht * vt);
        h     = p % ht;
        v     = p / ht;
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.hs  = (h >= hss) && (h < hse);
        o.vs  = (v >= vss) && (v < vse);
        o.hb  = (h >= ha);
        o.vb  = (v >= va);
        o.fs  = fs;
        o.fc  = 16'(fcb + n / (ht * vt));
        o.rgb = 12'h000;
        return o;
    endfunction

    function automatic obs_t model_d();
        return model(n_dm, fcb_dm, fs_dm, D_HA, D_HSS, D_HSE, D_HT, D_VA, D_VSS, D_VSE, D_VT);
    endfunction

    function automatic obs_t model_s();
        return model(n_sm, fcb_sm, fs_sm, S_HA, S_HSS, S_HSE, S_HT, S_VA, S_VSS, S_VSE, S_VT);
    endfunction

    function automatic obs_t sample_d();
        obs_t o;
        o.h = vif_d.hcount; o.v = vif_d.vcount; o.hs = vif_d.hsync; o.vs = vif_d.vsync;
        o.hb = vif_d.hblnk; o.vb = vif_d.vblnk; o.fs = fs_d; o.fc = fc_d; o.rgb = vif_d.rgb;
        return o;
    endfunction

    function automatic obs_t sample_s();
        obs_t o;
        o.h = vif_s.hcount; o.v = vif_s.vcount; o.hs = vif_s.hsync; o.vs = vif_s.vsync;
        o.hb = vif_s.hblnk; o.vb = vif_s.vblnk; o.fs = fs_s; o.fc = fc_s; o.rgb = vif_s.rgb;
        return o;
    endfunction

    function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                                input bit hb, input bit vb, input bit fs, input int fc);
        obs_t o;
        o.h = 11'(h); o.v = 11'(v); o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb;
        o.fs = fs; o.fc = 16'(fc); o.rgb = 12'h000;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("(h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b fc=%h rgb=%h)",
                         o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.fs, o.fc, o.rgb);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive at the falling edge, advance the model at the rising edge, sample 1 ns later.
    task automatic tick_d(input bit r, input bit e, input string name, input bit cmp);
        @(negedge clk);
        rst_d = r;
        en_d  = e;
        @(posedge clk);
        if (r) begin
            n_dm = 0; fcb_dm = 0; fs_dm = 1'b0;
        end else if (e) begin
            n_dm++;
            fs_dm = (n_dm % D_F == 0);
        end else begin
            fs_dm = 1'b0;
        end
        #1;
        if (cmp) check(name, sample_d(), model_d());
    endtask

    task automatic tick_s(input bit r, input bit e, input string name, input bit cmp);
        @(negedge clk);
        rst_s = r;
        en_s  = e;
        @(posedge clk);
        if (r) begin
            n_sm = 0; fcb_sm = 0; fs_sm = 1'b0;
        end else if (e) begin
            n_sm++;
            fs_sm = (n_sm % S_F == 0);
        end else begin
            fs_sm = 1'b0;
        end
        #1;
        if (cmp) check(name, sample_s(), model_s());
    endtask

    // Jump the default instance's raster position; called just after a sampling point.
    task automatic jump_d(input int h, input int v, input int fc);
        frc_h  = 11'(h);
        frc_v  = 11'(v);
        frc_fc = 16'(fc);
        force dut_d.hcount_q    = frc_h;
        force dut_d.vcount_q    = frc_v;
        force dut_d.frame_cnt_q = frc_fc;
        #1;
        release dut_d.hcount_q;
        release dut_d.vcount_q;
        release dut_d.frame_cnt_q;
        n_dm   = longint'(v) * D_HT + longint'(h);
        fcb_dm = fc;
    endtask

    vec_t   tbl[9];
    int     hs_cnt[3], hb_cnt[3], rise_h[3];
    int     pulses, first_pulse, vs_lines, vb_lines, first_vs_line;
    bit     prev_hs;

    initial begin
        tbl[0] = '{rst: 1, en: 0, exp: mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{rst: 0, en: 1, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2] = '{rst: 0, en: 0, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3] = '{rst: 0, en: 1, exp: mk(2, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4] = '{rst: 0, en: 1, exp: mk(3, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{rst: 0, en: 1, exp: mk(4, 0, 0, 0, 1, 0, 0, 0)};
        tbl[6] = '{rst: 0, en: 1, exp: mk(5, 0, 1, 0, 1, 0, 0, 0)};
        tbl[7] = '{rst: 1, en: 1, exp: mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[8] = '{rst: 0, en: 1, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};

        // ---- small instance: hand vectors ----
        for (int i = 0; i < 9; i++) begin
            tick_s(tbl[i].rst, tbl[i].en, "s_table", 1'b0);
            check($sformatf("s_table[%0d]", i), sample_s(), tbl[i].exp);
        end

        // Three full frames from reset, every cycle against the model.
        tick_s(1'b1, 1'b0, "s_reset", 1'b1);
        pulses = 0;
        for (int i = 0; i < 3 * S_F; i++) begin
            tick_s(1'b0, 1'b1, "s_free", 1'b1);
            if (fs_s) pulses++;
        end
        check_val("s_frame_pulses", pulses, 3);
        check_val("s_frame_cnt_after_3", fc_s, 3);

        // Enable dropped while sitting at (0,0): the pulse must not linger.
        tick_s(1'b0, 1'b0, "s_hold_origin", 1'b1);
        check_val("s_hold_origin_fs", fs_s, 0);

        // Mid-frame reset: the next pulse comes a whole frame of enabled cycles later.
        for (int i = 0; i < 17; i++) tick_s(1'b0, 1'b1, "s_pre_rst", 1'b1);
        tick_s(1'b1, 1'b1, "s_mid_rst", 1'b1);
        first_pulse = -1;
        for (int i = 1; i <= S_F + 3; i++) begin
            tick_s(1'b0, 1'b1, "s_post_rst", 1'b1);
            if (fs_s && first_pulse < 0) first_pulse = i;
        end
        check_val("s_first_pulse_after_rst", first_pulse, S_F);

        // Randomised enable and occasional reset.
        for (int i = 0; i < 800; i++) begin
            tick_s($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, "s_rand", 1'b1);
        end
        tick_s(1'b0, 1'b0, "s_idle", 1'b0);

        // ---- default instance ----
        tick_d(1'b1, 1'b0, "d_reset", 1'b1);
        tick_d(1'b1, 1'b1, "d_reset_over_en", 1'b1);
        tick_d(1'b0, 1'b1, "d_first_enabled", 1'b1);
        check_val("d_first_hcount", vif_d.hcount, 1);

        for (int l = 0; l < 3; l++) begin
            hs_cnt[l] = 0; hb_cnt[l] = 0; rise_h[l] = -1;
        end
        prev_hs = 1'b0;
        while (n_dm < 3 * D_HT) begin
            tick_d(1'b0, 1'b1, "d_lines", 1'b1);
            if (vif_d.vcount < 3) begin
                if (vif_d.hsync) hs_cnt[vif_d.vcount]++;
                if (vif_d.hblnk) hb_cnt[vif_d.vcount]++;
                if (vif_d.hsync && !prev_hs) rise_h[vif_d.vcount] = int'(vif_d.hcount);
            end
            prev_hs = vif_d.hsync;
        end
        for (int l = 0; l < 3; l++) begin
            check_val($sformatf("d_hsync_cycles[%0d]", l), hs_cnt[l], 128);
            check_val($sformatf("d_hblnk_cycles[%0d]", l), hb_cnt[l], 256);
            check_val($sformatf("d_hsync_rise[%0d]", l), rise_h[l], 840);
        end

        // Enable gating just before the sync pulse.
        while (n_dm % D_HT != 839) tick_d(1'b0, 1'b1, "d_to_839", 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick_d(1'b0, 1'b0, "d_gated", 1'b1);
            check_val("d_gated_hcount", vif_d.hcount, 839);
            check_val("d_gated_hsync", vif_d.hsync, 0);
        end
        tick_d(1'b0, 1'b1, "d_ungated", 1'b1);
        check_val("d_ungated_hcount", vif_d.hcount, 840);
        check_val("d_ungated_hsync", vif_d.hsync, 1);

        // Vertical span from line 597 through the frame wrap.
        jump_d(1054, 597, 5);
        vs_lines = 0; vb_lines = 0; first_vs_line = -1;
        while (n_dm < D_F) begin
            tick_d(1'b0, 1'b1, "d_vertical", 1'b1);
            if (vif_d.hcount == 0 && vif_d.vcount != 0) begin
                if (vif_d.vsync) begin
                    vs_lines++;
                    if (first_vs_line < 0) first_vs_line = int'(vif_d.vcount);
                end
                if (vif_d.vblnk) vb_lines++;
            end
        end
        check_val("d_vsync_lines", vs_lines, 4);
        check_val("d_vsync_first_line", first_vs_line, 601);
        check_val("d_vblnk_lines", vb_lines, 28);
        check_val("d_wrap_fs", fs_d, 1);
        check_val("d_wrap_fc", fc_d, 6);
        tick_d(1'b0, 1'b1, "d_after_wrap", 1'b1);
        check_val("d_after_wrap_fs", fs_d, 0);
        check_val("d_after_wrap_hcount", vif_d.hcount, 1);

        // frame_cnt rollover at the wrap.
        jump_d(1054, 627, 16'hFFFF);
        tick_d(1'b0, 1'b1, "d_roll_pre", 1'b1);
        tick_d(1'b0, 1'b1, "d_roll_wrap", 1'b1);
        check_val("d_roll_fc", fc_d, 0);
        check_val("d_roll_fs", fs_d, 1);

        // Reset in the middle of a frame.
        jump_d(498, 300, 3);
        tick_d(1'b0, 1'b1, "d_mid_pre", 1'b1);
        tick_d(1'b0, 1'b1, "d_mid_at_500", 1'b1);
        check_val("d_mid_pos", {vif_d.vcount, vif_d.hcount}, {11'd300, 11'd500});
        tick_d(1'b1, 1'b1, "d_mid_rst", 1'b1);
        check("d_mid_rst_zero", sample_d(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            tick_d(1'b0, 1'b1, "d_post_rst", 1'b1);
            if (fs_d) pulses++;
        end
        check_val("d_post_rst_pulses", pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
